rdc_reset_sequencer: RTL and testbench

RDC_RESET_SEQUENCER -- requirements
Module: rdc_reset_sequencer

---
 rtl/rdc_reset_sequencer_pkg.sv | 27 ++
 rtl/rdc_reset_sequencer_phase_timer.sv | 25 ++
 rtl/rdc_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_rdc_reset_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rdc_reset_sequencer_pkg.sv
// Shared definitions for the RDC reset sequencer: state encoding,
// default timing constants and the phase-timer width helper.
package rdc_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISO,
    ST_ASSERT_B,
    ST_ASSERT_A,
    ST_HOLD,
    ST_RELEASE_A,
    ST_RELEASE_B,
    ST_UNISO
  } seq_state_e;

  localparam int unsigned DEFAULT_GAP_CYCLES  = 2;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 4;

  // Width of a down-counter able to hold the longer of the two phase lengths.
  function automatic int unsigned phase_count_width(input int unsigned gap,
                                                    input int unsigned hold);
    int unsigned longest;
    longest = (gap > hold) ? gap : hold;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rdc_reset_sequencer_phase_timer.sv
// rdc_phase_timer: loadable down-counter with a zero flag. A load of N
// makes the flag rise N cycles later; the count then rests at zero.
module rdc_phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_q;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      count_q <= i_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/rdc_reset_sequencer.sv
// rdc_reset_sequencer: orders reset and isolation edges between a source
// domain A and a destination domain B so that B is held in reset (and, with
// RDC_RST_SEQ_ISO_EN defined, the A->B path is clamped) whenever A enters or
// leaves reset. Without RDC_RST_SEQ_ISO_EN the ISO/UNISO phases are skipped
// and o_iso_b stays 0.
//
// Timing notes:
//  - Every phase lasts GAP_CYCLES except HOLD. After an assert phase, HOLD is
//    shortened so the reset stays low HOLD_CYCLES in total (at least one HOLD
//    cycle is always kept, so the low time is never below GAP_CYCLES + 1).
//    Coming out of i_rst, HOLD runs its full HOLD_CYCLES.
//  - IDLE ignores requests in the cycle it is entered (the o_done cycle), so
//    held or pending requests start one cycle after o_done.
module rdc_reset_sequencer
  import rdc_reset_sequencer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_rst_a,
  output logic o_rst_b,
  output logic o_iso_b,
  output logic o_busy,
  output logic o_done
);

`ifdef RDC_RST_SEQ_ISO_EN
  localparam bit ISO_EN = 1'b1;
`else
  localparam bit ISO_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = phase_count_width(GAP_CYCLES, HOLD_CYCLES);
  localparam int unsigned HOLD_AFTER_ASSERT =
    (HOLD_CYCLES > GAP_CYCLES) ? (HOLD_CYCLES - GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GAP_LOAD        = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD       = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SHORT_LOAD = CNT_W'(HOLD_AFTER_ASSERT - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD       = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic             seq_a_q, seq_a_d;
  logic             pending_q, pending_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;
  logic             rst_a_d, rst_b_d, iso_d, busy_d, done_d;

  rdc_phase_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_load  (timer_load),
    .i_value (timer_value),
    .o_zero  (timer_zero)
  );

  // State, sequence type, pending flag and all outputs are registered here;
  // reset parks the sequencer in HOLD of an A sequence.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= ST_HOLD;
      seq_a_q   <= 1'b1;
      pending_q <= 1'b0;
      o_rst_a   <= 1'b0;
      o_rst_b   <= 1'b0;
      o_iso_b   <= ISO_EN;
      o_busy    <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_a_q   <= seq_a_d;
      pending_q <= pending_d;
      o_rst_a   <= rst_a_d;
      o_rst_b   <= rst_b_d;
      o_iso_b   <= iso_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
    end
  end

  // Next-state, timer reload and next-output decode; outputs follow the
  // state being entered so every edge lands on its state's first cycle.
  always_comb begin
    state_d     = state_q;
    seq_a_d     = seq_a_q;
    pending_d   = pending_q;
    timer_load  = 1'b0;
    timer_value = '0;

    if (!i_rst) begin
      timer_load  = 1'b1;
      timer_value = HOLD_LOAD;
    end else begin
      if ((state_q != ST_IDLE) && !seq_a_q && i_req_a) begin
        pending_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (timer_zero && (i_req_a || pending_q)) begin
            seq_a_d   = 1'b1;
            pending_d = 1'b0;
            state_d   = ISO_EN ? ST_ISO : ST_ASSERT_B;
          end else if (timer_zero && i_req_b) begin
            seq_a_d = 1'b0;
            state_d = ST_ASSERT_B;
          end
        end
        ST_ISO:       if (timer_zero) state_d = ST_ASSERT_B;
        ST_ASSERT_B:  if (timer_zero) state_d = seq_a_q ? ST_ASSERT_A : ST_HOLD;
        ST_ASSERT_A:  if (timer_zero) state_d = ST_HOLD;
        ST_HOLD:      if (timer_zero) state_d = seq_a_q ? ST_RELEASE_A : ST_RELEASE_B;
        ST_RELEASE_A: if (timer_zero) state_d = ST_RELEASE_B;
        ST_RELEASE_B: begin
          if (timer_zero) begin
            state_d = (seq_a_q && ISO_EN) ? ST_UNISO : ST_IDLE;
          end
        end
        ST_UNISO:     if (timer_zero) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
        timer_load = 1'b1;
        case (state_d)
          ST_IDLE: timer_value = IDLE_LOAD;
          ST_HOLD: timer_value = HOLD_SHORT_LOAD;
          default: timer_value = GAP_LOAD;
        endcase
      end
    end

    rst_a_d = !(seq_a_d && (state_d inside {ST_ASSERT_A, ST_HOLD}));
    rst_b_d = !((state_d inside {ST_ASSERT_B, ST_HOLD}) ||
                (seq_a_d && (state_d inside {ST_ASSERT_A, ST_RELEASE_A})));
    iso_d   = ISO_EN && seq_a_d &&
              (state_d inside {ST_ISO, ST_ASSERT_B, ST_ASSERT_A, ST_HOLD,
                               ST_RELEASE_A, ST_RELEASE_B});
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_rdc_reset_sequencer.sv
// Testbench for rdc_reset_sequencer. The reference model describes each
// sequence as a set of edge times computed from the phase lengths; outputs
// are compared on every falling clock edge. Honours RDC_RST_SEQ_ISO_EN.
module tb_rdc_reset_sequencer;

  localparam int G = 2;
  localparam int H = 4;
  localparam int L = (H > G) ? H : G + 1;
`ifdef RDC_RST_SEQ_ISO_EN
  localparam bit ISO = 1'b1;
`else
  localparam bit ISO = 1'b0;
`endif
  localparam int I = ISO ? G : 0;

  logic i_clk = 1'b0;
  logic i_rst, i_req_a, i_req_b;
  logic o_rst_a, o_rst_b, o_iso_b, o_busy, o_done;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  int m_a_lo, m_a_hi, m_b_lo, m_b_hi, m_iso_lo, m_iso_hi, m_done;
  bit m_is_a;
  bit m_pending = 1'b0;
  bit m_valid   = 1'b0;

  rdc_reset_sequencer #(
    .GAP_CYCLES  (G),
    .HOLD_CYCLES (H)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req_a (i_req_a),
    .i_req_b (i_req_b),
    .o_rst_a (o_rst_a),
    .o_rst_b (o_rst_b),
    .o_iso_b (o_iso_b),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  // A sequence whose first phase starts at cycle s.
  task automatic model_launch_a(input int s);
    m_is_a   = 1'b1;
    m_iso_lo = s;
    m_b_lo   = s + I;
    m_a_lo   = m_b_lo + G;
    m_a_hi   = m_a_lo + L;
    m_b_hi   = m_a_hi + G;
    m_iso_hi = m_b_hi + G;
    m_done   = m_b_hi + G + I;
  endtask

  // B-only sequence whose first phase starts at cycle s.
  task automatic model_launch_b(input int s);
    m_is_a   = 1'b0;
    m_a_lo   = 0;
    m_a_hi   = 0;
    m_iso_lo = 0;
    m_iso_hi = 0;
    m_b_lo   = s;
    m_b_hi   = s + L;
    m_done   = m_b_hi + G;
  endtask

  // Reset sampled low at the edge ending cycle k: everything held, and the
  // release half of an A sequence follows a full HOLD after the last low sample.
  task automatic model_reset(input int k);
    m_is_a    = 1'b1;
    m_a_lo    = -1;
    m_b_lo    = -1;
    m_iso_lo  = -1;
    m_a_hi    = k + 1 + H;
    m_b_hi    = m_a_hi + G;
    m_iso_hi  = m_b_hi + G;
    m_done    = m_b_hi + G + I;
    m_pending = 1'b0;
    m_valid   = 1'b1;
  endtask

  task automatic model_sample(input int k, input bit ra, input bit rb, input bit rst);
    if (!rst) begin
      model_reset(k);
    end else if (m_valid) begin
      if (k < m_done) begin
        if (!m_is_a && ra) m_pending = 1'b1;
      end else if (k > m_done) begin
        if (ra || m_pending) begin
          model_launch_a(k + 1);
          m_pending = 1'b0;
        end else if (rb) begin
          model_launch_b(k + 1);
        end
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Compare every output of the current cycle against the model.
  task automatic checkOutput();
    if (m_valid) begin
      check_bit("rst_a", o_rst_a, !(cyc >= m_a_lo && cyc < m_a_hi));
      check_bit("rst_b", o_rst_b, !(cyc >= m_b_lo && cyc < m_b_hi));
      check_bit("iso_b", o_iso_b, ISO && m_is_a && cyc >= m_iso_lo && cyc < m_iso_hi);
      check_bit("busy",  o_busy,  cyc < m_done);
      check_bit("done",  o_done,  cyc == m_done);
      check_bit("rst_a_low_implies_rst_b_low", o_rst_a | ~o_rst_b, 1'b1);
    end
  endtask

  // Check this cycle, drive the next inputs, advance one clock.
  task automatic applyStimulus(input bit ra, input bit rb, input bit rst);
    checkOutput();
    i_req_a = ra;
    i_req_b = rb;
    i_rst   = rst;
    model_sample(cyc, ra, rb, rst);
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    i_rst   = 1'b0;
    i_req_a = 1'b0;
    i_req_b = 1'b0;

    // Power-on: reset low for 5 cycles, then ordered release.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    idle(16);

    // Single-cycle A request.
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(18);

    // Single-cycle B request.
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle(10);

    // A and B together: A wins, one done.
    applyStimulus(1'b1, 1'b1, 1'b1);
    idle(18);

    // B, then A three cycles later becomes pending.
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(26);

    // Reset dropped at cycle 6 of an A sequence.
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle(18);

    // Requests held high re-trigger back to back.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    idle(12);

    // Random requests with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom % 10) == 0, ($urandom % 7) == 0,
                    ($urandom % 160) != 0);
    end
    idle(20);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
